// File: rtl/matmul_sequencer.sv
// matmul_sequencer: steps one dot-product engine across an [M x N]*[N x O] multiply, buffering and writing C row by row.
module matmul_sequencer #(
  parameter int BATCH_SIZE = 8,
  parameter int LOG_BATCH_SIZE = 3,
  parameter int OUTPUT_FEATURES = 8,
  parameter int LOG_OUTPUT_FEATURES = 3,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err,
  output logic [LOG_BATCH_SIZE-1:0] inputAddr,
  output logic [LOG_OUTPUT_FEATURES-1:0] weightAddr,
  output logic dp_start,
  input  logic dp_valid,
  input  logic [OUTPUT_WIDTH-1:0] dp_result,
  output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
  output logic [LOG_BATCH_SIZE-1:0] outputAddr,
  output logic outputWrEn,
  input  logic wr_ready
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state, stateNext;
  logic [LOG_BATCH_SIZE-1:0] row;
  logic [LOG_OUTPUT_FEATURES-1:0] col;
  logic lastCol, lastRow;
  assign lastCol = col == LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
  assign lastRow = row == LOG_BATCH_SIZE'(BATCH_SIZE - 1);
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  stateNext = start ? LOAD : IDLE;
      LOAD:  stateNext = ISSUE;
      ISSUE: stateNext = WAIT;
      WAIT:  stateNext = dp_valid ? (lastCol ? WRITE : LOAD) : WAIT;
      WRITE: stateNext = wr_ready ? (lastRow ? DONE : LOAD) : WRITE;
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = IDLE;
    busy = state != IDLE;
    done = state == DONE;
    dp_start = state == ISSUE;
    outputWrEn = state == WRITE;
    inputAddr = row;
    outputAddr = row;
    weightAddr = col;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      err <= 1'b0;
      outputData <= '0;
    end else begin
      state <= stateNext;
      if (abort) begin
        row <= '0;
        col <= '0;
      end else if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
        err <= 1'b0;
      end else if (state == WAIT && dp_valid) begin
        outputData[col*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= dp_result;
        col <= lastCol ? col : col + 1'b1;
      end else if (state == WRITE && wr_ready && !lastRow) begin
        row <= row + 1'b1;
        col <= '0;
      end
      // a result strobe outside WAIT is dropped but remembered
      if (dp_valid && state != WAIT) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed checks of matmul_sequencer against an L=3 engine model and a stallable write sink.
module tb_matmul_sequencer;
  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic busy, done, err, dpStart, outputWrEn;
  logic [2:0] inputAddr, weightAddr, outputAddr;
  logic [127:0] outputData;
  logic engValid = 0, strayValid = 0, wrReady = 1;
  logic [15:0] engRes = 0, engNext;
  logic dpValid;
  logic [15:0] dpResult;
  int vectors = 0, miscompares = 0;
  int edges = 0, startEdge = 0, gen = 0, engGen, stall = 0, wcnt = 0;
  int dpStarts = 0, doneCnt = 0, doneCyc = -1, nWr = 0;
  logic [127:0] wrData[16];
  logic [2:0] wrAddr[16];
  logic holdValid = 0;
  logic [127:0] holdData;
  logic [2:0] holdAddr;
  logic found;

  assign dpValid = engValid | strayValid;
  assign dpResult = engValid ? engRes : 16'hDEAD;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .inputAddr(inputAddr), .weightAddr(weightAddr), .dp_start(dpStart), .dp_valid(dpValid),
    .dp_result(dpResult), .outputData(outputData), .outputAddr(outputAddr),
    .outputWrEn(outputWrEn), .wr_ready(wrReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rowData(input int r);
    logic [127:0] d;
    for (int c = 0; c < 8; c++) d[c*16 +: 16] = 16'(16*r + c);
    return d;
  endfunction

  // engine: result for the addresses presented at ISSUE, strobed so the 3rd edge after dp_start's edge samples it
  always begin
    @(posedge clk); #1;
    if (dpStart) begin
      engGen = gen;
      engNext = 16'(16*inputAddr + weightAddr);
      repeat (3) @(posedge clk);
      #1;
      if (engGen == gen) begin engValid = 1; engRes = engNext; end
      @(posedge clk); #1;
      engValid = 0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (outputWrEn) begin wrReady = wcnt >= stall; wcnt++; end
    else begin wcnt = 0; wrReady = stall == 0; end
  end

  always @(negedge clk) begin
    if (dpStart) dpStarts++;
    if (done) begin doneCnt++; doneCyc = edges - startEdge; end
    if (outputWrEn && wrReady && nWr < 16) begin
      wrAddr[nWr] = outputAddr;
      wrData[nWr] = outputData;
      nWr++;
    end
    if (outputWrEn) begin
      if (holdValid) begin
        check("stallAddr", outputAddr, holdAddr);
        check("stallData", outputData, holdData);
      end
      holdValid = !wrReady;
      holdAddr = outputAddr;
      holdData = outputData;
    end else holdValid = 0;
  end

  task automatic startRun();
    @(negedge clk);
    start = 1;
    nWr = 0; dpStarts = 0; doneCnt = 0; doneCyc = -1;
    startEdge = edges;
    @(negedge clk);
    start = 0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 1000 && doneCnt == 0; i++) @(posedge clk);
    if (doneCnt == 0) check("doneTimeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic checkRun(input int expCyc, input logic expErr);
    check("doneCnt", doneCnt, 1);
    check("doneCyc", doneCyc, expCyc);
    check("dpStarts", dpStarts, 64);
    check("nWr", nWr, 8);
    for (int r = 0; r < 8 && r < nWr; r++) begin
      check("wrAddr", wrAddr[r], r);
      check("wrData", wrData[r], rowData(r));
    end
    check("err", err, expErr);
    check("busyAfter", busy, 0);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "Busy"}, busy, 0);
    check({tag, "Done"}, done, 0);
    check({tag, "Err"}, err, 0);
    check({tag, "DpStart"}, dpStart, 0);
    check({tag, "WrEn"}, outputWrEn, 0);
    check({tag, "Addrs"}, {inputAddr, weightAddr, outputAddr}, 0);
    check({tag, "Data"}, outputData, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkZero("reset");
    reset = 0;
    @(negedge clk);
    checkZero("postReset");

    startRun();
    check("busyCycle1", busy, 1);
    waitDone();
    checkRun(329, 0);

    stall = 4;
    startRun();
    waitDone();
    checkRun(361, 0);
    stall = 0;

    startRun();
    repeat (9) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (189) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    waitDone();
    checkRun(329, 0);

    startRun();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = busy && inputAddr == 2 && weightAddr == 0 && !dpStart && !outputWrEn;
    end
    check("strayFound", found, 1);
    strayValid = 1;
    @(posedge clk); #1;
    strayValid = 0;
    waitDone();
    checkRun(329, 1);
    repeat (3) @(negedge clk);
    check("errSticky", err, 1);

    startRun();
    check("errCleared", err, 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = dpStart && inputAddr == 3 && weightAddr == 5;
    end
    check("abortFound", found, 1);
    @(negedge clk);
    abort = 1;
    gen++;
    @(posedge clk); #1;
    abort = 0;
    check("abortBusy", busy, 0);
    check("abortAddrs", {inputAddr, weightAddr, outputAddr}, 0);
    check("abortErr", err, 0);
    check("abortBuf", outputData, {rowData(2)[127:80], rowData(3)[79:0]});
    repeat (20) @(negedge clk);
    check("abortNoWr", nWr, 3);
    check("abortNoDone", doneCnt, 0);
    check("abortIdle", busy, 0);
    startRun();
    waitDone();
    checkRun(329, 0);

    stall = 4;
    startRun();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = outputWrEn && outputAddr == 1;
    end
    check("resetFound", found, 1);
    #1 reset = 1;
    gen++;
    #1 checkZero("asyncReset");
    #1 reset = 0;
    repeat (20) @(negedge clk);
    check("resetNoDone", doneCnt, 0);
    check("resetIdle", busy, 0);
    stall = 0;
    startRun();
    waitDone();
    checkRun(329, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control FSM that sequences one dot-product engine across a full [M×N]·[N×O] matrix multiply. It steps the row address of A (`inputAddr`) and the row address of Bᵀ (`weightAddr`), and pulses the engine's start. It collects the O scalar results into a row buffer and writes each completed row of C with a backpressured write handshake. It sits between the host/DMA command interface and the dot-product datapath, replacing free-running state counters with an explicit start/busy/done protocol.

## Interface
- `BATCH_SIZE`, default 8: M, rows of A and of C.
- `LOG_BATCH_SIZE`, default 3: address width for rows of A and C.
- `OUTPUT_FEATURES`, default 8: O, rows of Bᵀ and columns of C.
- `LOG_OUTPUT_FEATURES`, default 3: address width for rows of Bᵀ.
- `OUTPUT_WIDTH`, default 16: width of one C element.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a multiply; accepted only in IDLE.
- `abort` in 1: synchronous return to IDLE from any state.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last row of C has been written.
- `err` out 1: sticky flag; cleared when a new `start` is accepted.
- `inputAddr` out LOG_BATCH_SIZE: row of A.
- `weightAddr` out LOG_OUTPUT_FEATURES: row of Bᵀ.
- `dp_start` out 1: one-cycle start pulse to the dot-product engine.
- `dp_valid` in 1: the engine's result-ready strobe.
- `dp_result` in OUTPUT_WIDTH: the engine's scalar result.
- `outputData` out OUTPUT_FEATURES*OUTPUT_WIDTH: one row of C.
- `outputAddr` out LOG_BATCH_SIZE: row index of C.
- `outputWrEn` out 1: write request, held until accepted.
- `wr_ready` in 1: the write sink accepts the row in a cycle where `outputWrEn` is also high.

## Operation
- **Reset:** state=IDLE, row=0, col=0, row buffer=0. All outputs are 0.
- **Counters:**
  - `row` drives `inputAddr` and `outputAddr`.
  - `col` drives `weightAddr`.
  - Both are registered.
- **IDLE**
  - `start` → row=0, col=0, err=0, go to LOAD.
  - All other inputs are ignored.
- **LOAD:** addresses are stable for one cycle to cover the 1-cycle memory read latency; go to ISSUE.
- **ISSUE:** `dp_start`=1 for exactly this cycle; go to WAIT.
- **WAIT:** on `dp_valid`:
  - Store `dp_result` in `outputData[col*OUTPUT_WIDTH +: OUTPUT_WIDTH]`.
  - If col==O−1, go to WRITE.
  - Otherwise col+1, go to LOAD.
- **WRITE:** `outputWrEn`=1 and `outputAddr`=row, held stable until `wr_ready`. On `wr_ready`:
  - If row==M−1, go to DONE.
  - Otherwise row+1, col=0, go to LOAD.
- **DONE:** `done`=1 for one cycle; go to IDLE. Counters keep their final values.
- **Unexpected `dp_valid`:** asserted in any state other than WAIT → err=1; the result is discarded and the state is unchanged.
- **`start` while busy:** ignored. It does not set err.
- **Abort:**
  - `abort` has priority over every other transition; it also overrides a simultaneous `start` in IDLE.
  - Next state is IDLE with col=0 and row=0.
  - `dp_start`, `outputWrEn` and `done` are 0 from the following cycle.
  - The row buffer and err keep their values.
- **Row buffer:** not cleared between rows; every element is overwritten before each WRITE.
- **Output registering:** all outputs are registered; none depends combinationally on inputs.

## Timing
- **Per element:** LOAD (1) + ISSUE (1) + WAIT (L). L ≥ 1 is the number of cycles from the `dp_start` edge to the first edge that samples `dp_valid` high.
- **Per row:** O·(2+L) cycles plus W. W ≥ 1 is the number of WRITE cycles; W=1 when `wr_ready` is held high.
- **Whole multiply:** `start` is sampled at cycle 0; LOAD is cycle 1. `done` is high in cycle M·(O·(2+L)+W)+1, and `busy` falls in the following cycle.
- **Back-to-back:** `start` is accepted in the first IDLE cycle after DONE.
- **Async reset mid-operation:** forces the reset values immediately, regardless of `clk`.

## Test plan
- **Full run, ideal sink:** defaults, engine model with L=3 returning result=16·row+col, `wr_ready`=1.
  - 8 writes occur; row r has element c = 16r+c.
  - `done` is high in cycle 8·(8·5+1)+1=329.
  - `dp_start` pulses exactly 64 times.
- **Backpressure:** as the full run, but `wr_ready` is low for 4 cycles on every row.
  - `outputWrEn`, `outputAddr` and `outputData` are stable while stalled.
  - `done` is high in cycle 8·(8·5+5)+1=361.
- **`start` while busy:** assert `start` at cycles 10 and 200 of a run.
  - No restart; timing is identical to the full run; err=0.
- **Stray `dp_valid`:** pulse `dp_valid` during LOAD of row 2.
  - err=1 until the next accepted `start`; C data is unaffected.
- **Abort mid-row:** assert `abort` in WAIT with row=3, col=5.
  - IDLE, busy=0, addresses 0 on the next cycle; no write or `done` follows.
  - A fresh `start` completes a correct full run.
- **Async reset:** pulse `reset` between clock edges during WRITE.
  - All outputs are 0 before the next edge.
  - No `done`; the FSM then accepts `start`.
